cam_pixel_capture: RTL and testbench
====================================

Name: cam_pixel_capture

Overview:
Parametrised camera pixel front end for the OV7670-style 8-bit parallel bus, clocked by the camera pixel clock.
- Assembles two-byte pixels in RGB565, RGB555 or RGB444 format, selected at runtime.
- Expands each colour to 8 bits per channel and tracks pixel x/y position within the frame.
- Flags malformed lines and frames.
- Feeds the frame buffer writer and the encryption datapath.

Parameters:
H_SIZE, 640, active pixels per line
V_SIZE, 480, active lines per frame
HI_BYTE_FIRST, 1, 1 = byte carrying red arrives first on each pixel; 0 = swapped

Ports:
Cam_pclk  input  1  pixel clock; all logic on rising edge
Reset_n  input  1  asynchronous active-low reset
Cam_vsync  input  1  high = vertical blanking
Cam_href  input  1  high = valid data byte on Cam_data
Cam_data  input  8  camera data byte
Mode  input  2  0 = RGB565, 1 = RGB555, 2 = RGB444 (xR/GB), 3 = treated as RGB565
red, green, blue  output  8 each  expanded pixel colour
pix_valid  output  1  one-cycle strobe; pixel outputs valid
pix_x  output  $clog2(H_SIZE)  column of current pixel
pix_y  output  $clog2(V_SIZE)  row of current pixel
frame_start  output  1  high with pix_valid on pixel (0,0)
frame_done  output  1  one-cycle pulse after line V_SIZE-1 ends
line_err  output  1  one-cycle pulse on malformed or aborted line

Behaviour:
- Reset (async, Reset_n = 0): all outputs 0; state WAIT_FRAME; byte phase 0; x = y = 0; mode_q = 0.
- Cam_vsync is registered once (vs_q). A vsync fall is detected when vs_q = 1 and Cam_vsync = 0.
- States:
  - WAIT_FRAME: on vsync fall, latch Mode into mode_q, set y = 0, go to WAIT_LINE. All href activity here is ignored.
  - WAIT_LINE: when Cam_href = 1 and Cam_vsync = 0, go to ACTIVE. That same edge samples the first byte: phase becomes 1 and x = 0.
  - ACTIVE, Cam_href = 1: bytes alternate phase 0 then phase 1.
    - Phase 0 byte is stored in byte0.
    - On the phase-1 edge, when x < H_SIZE: register red/green/blue, pix_x = x, pix_y = y; assert pix_valid for exactly one cycle; x increments.
    - When x >= H_SIZE: the pixel is dropped (no strobe) and the line is marked bad.
  - ACTIVE, Cam_href = 0 (line end):
    - line_err pulses if x != H_SIZE, if phase = 1 (odd byte count), or if the line was marked bad.
    - y increments. If the new y equals V_SIZE, pulse frame_done and go to WAIT_FRAME; otherwise go to WAIT_LINE.
  - Cam_vsync = 1 in WAIT_LINE or ACTIVE (early frame end): pulse line_err if in ACTIVE or y != 0; go to WAIT_FRAME; no frame_done.
- Pixel latency: outputs update on the same edge that samples the second byte. The next edge clears pix_valid unless that edge completes another pixel. Back-to-back pixels give pix_valid high on every second edge.
- Byte order: with HI_BYTE_FIRST = 1, the first byte is hi and the second is lo. With HI_BYTE_FIRST = 0 the roles swap.
- Decode (hi = bits 15:8, lo = bits 7:0 of the 16-bit word):
  - RGB565: R5 = hi[7:3], G6 = {hi[2:0], lo[7:5]}, B5 = lo[4:0].
  - RGB555: R5 = hi[6:2], G5 = {hi[1:0], lo[7:5]}, B5 = lo[4:0].
  - RGB444: R4 = hi[3:0], G4 = lo[7:4], B4 = lo[3:0].
- Expansion to 8 bits by MSB replication:
  - 5-bit: {c, c[4:2]}
  - 6-bit: {c, c[5:4]}
  - 4-bit: {c, c}
- Mode changes mid-frame have no effect until the next vsync fall. mode_q = 3 decodes as RGB565.
- frame_start = pix_valid with x = 0 and y = 0.
- red, green, blue, pix_x and pix_y hold their last values between strobes.
- Reset asserted mid-line discards the partial pixel. After release, capture starts only at the next vsync fall.

Test Plan:
- RGB565, H_SIZE = 4, V_SIZE = 2, hi byte first, after vsync fall, bytes F8 00 -> red = FF, green = 00, blue = 00, pix_valid one cycle, pix_x = 0, pix_y = 0, frame_start = 1.
- Mode = 2, bytes 0A 5F -> red = AA, green = 55, blue = FF. Mode set to 0 mid-frame -> decode stays RGB444 until the next vsync fall.
- Full 4x2 frame -> 8 strobes with (x, y) sequencing (0,0)..(3,1); frame_done pulses once after the second href fall; line_err never pulses.
- Line of 7 bytes -> 3 strobes, line_err pulses at href fall. Line of 12 bytes -> 4 strobes, extra pixels dropped, line_err pulses.
- vsync rises after the first line only -> line_err pulses, no frame_done; the next frame restarts at pix_y = 0.
- Reset_n pulsed low after one byte of a pixel -> all outputs 0 immediately; no strobe until a new vsync fall followed by two bytes.
- HI_BYTE_FIRST = 0, RGB565 bytes 1F 00 -> blue = FF, red = 00, green = 00.

Source files
------------

// File: rtl/cam_pixel_capture_if.sv
// Camera byte bus in, expanded RGB888 pixel stream plus frame/line status out.
// master = camera/source side, slave = capture block.
interface cam_pixel_capture_if #(
  parameter int H_SIZE = 640,
  parameter int V_SIZE = 480
);
  localparam int XW = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int YW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;

  logic          Cam_vsync;
  logic          Cam_href;
  logic [7:0]    Cam_data;
  logic [1:0]    Mode;

  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic          frame_done;
  logic          line_err;

  modport master (
    output Cam_vsync, Cam_href, Cam_data, Mode,
    input  red, green, blue, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err
  );

  modport slave (
    input  Cam_vsync, Cam_href, Cam_data, Mode,
    output red, green, blue, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err
  );
endinterface

// File: rtl/cam_pixel_capture.sv
// Two-byte RGB565/555/444 pixel assembly with x/y tracking; pixel registered on the
// edge sampling its second byte. No backpressure: the camera bus cannot be stalled.
module cam_pixel_capture #(
  parameter int H_SIZE        = 640,
  parameter int V_SIZE        = 480,
  parameter bit HI_BYTE_FIRST = 1'b1
) (
  input logic                Cam_pclk,
  input logic                Reset_n,
  cam_pixel_capture_if.slave bus
);
  localparam int XW  = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int YW  = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;
  // Counters need one extra code so they can reach H_SIZE / V_SIZE.
  localparam int XCW = $clog2(H_SIZE + 1);
  localparam int YCW = $clog2(V_SIZE + 1);
  localparam logic [XCW-1:0] H_MAX = XCW'(H_SIZE);
  localparam logic [YCW-1:0] V_MAX = YCW'(V_SIZE);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_LINE,
    ACTIVE
  } state_t;

  state_t         state;
  logic           vs_q;
  logic [1:0]     mode_q;
  logic [7:0]     byte0;
  logic           phase;
  logic           bad;
  logic [XCW-1:0] x;
  logic [YCW-1:0] y;

  logic           vs_fall;
  logic [YCW-1:0] y_next;
  logic [7:0]     hi;
  logic [7:0]     lo;
  logic [7:0]     r8;
  logic [7:0]     g8;
  logic [7:0]     b8;

  assign vs_fall = vs_q & ~bus.Cam_vsync;
  assign y_next  = y + 1'b1;
  assign hi      = HI_BYTE_FIRST ? byte0 : bus.Cam_data;
  assign lo      = HI_BYTE_FIRST ? bus.Cam_data : byte0;

  // Channel expansion replicates the MSBs so full scale maps to 8'hFF.
  always_comb begin
    r8 = 8'h00;
    g8 = 8'h00;
    b8 = 8'h00;
    case (mode_q)
      2'd1: begin
        r8 = {hi[6:2], hi[6:4]};
        g8 = {hi[1:0], lo[7:5], hi[1:0], lo[7]};
        b8 = {lo[4:0], lo[4:2]};
      end
      2'd2: begin
        r8 = {hi[3:0], hi[3:0]};
        g8 = {lo[7:4], lo[7:4]};
        b8 = {lo[3:0], lo[3:0]};
      end
      default: begin
        r8 = {hi[7:3], hi[7:5]};
        g8 = {hi[2:0], lo[7:5], hi[2:1]};
        b8 = {lo[4:0], lo[4:2]};
      end
    endcase
  end

  always_ff @(posedge Cam_pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state           <= WAIT_FRAME;
      vs_q            <= 1'b0;
      mode_q          <= 2'd0;
      byte0           <= 8'h00;
      phase           <= 1'b0;
      bad             <= 1'b0;
      x               <= '0;
      y               <= '0;
      bus.red         <= 8'h00;
      bus.green       <= 8'h00;
      bus.blue        <= 8'h00;
      bus.pix_valid   <= 1'b0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.line_err    <= 1'b0;
    end else begin
      vs_q            <= bus.Cam_vsync;
      bus.pix_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.line_err    <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (vs_fall) begin
            mode_q <= bus.Mode;
            y      <= '0;
            state  <= WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          if (bus.Cam_vsync) begin
            bus.line_err <= (y != '0);
            state        <= WAIT_FRAME;
          end else if (bus.Cam_href) begin
            byte0 <= bus.Cam_data;
            phase <= 1'b1;
            x     <= '0;
            bad   <= 1'b0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.Cam_vsync) begin
            bus.line_err <= 1'b1;
            phase        <= 1'b0;
            state        <= WAIT_FRAME;
          end else if (bus.Cam_href) begin
            if (!phase) begin
              byte0 <= bus.Cam_data;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x < H_MAX) begin
                bus.red         <= r8;
                bus.green       <= g8;
                bus.blue        <= b8;
                bus.pix_x       <= x[XW-1:0];
                bus.pix_y       <= y[YW-1:0];
                bus.pix_valid   <= 1'b1;
                bus.frame_start <= (x == '0) && (y == '0);
                x               <= x + 1'b1;
              end else begin
                bad <= 1'b1;
              end
            end
          end else begin
            // Line end: short, long or odd-length lines are all reported.
            bus.line_err <= (x != H_MAX) | phase | bad;
            phase        <= 1'b0;
            y            <= y_next;
            if (y_next == V_MAX) begin
              bus.frame_done <= 1'b1;
              state          <= WAIT_FRAME;
            end else begin
              state <= WAIT_LINE;
            end
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture on a 4x2 frame: expected pixels queued as bytes
// are driven, captured strobes compared against them at each line end.
module tb_cam_pixel_capture;
  localparam int H = 4;
  localparam int V = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] x;
    logic       y;
    logic       fs;
  } pix_t;

  logic Cam_pclk;
  logic Reset_n;

  cam_pixel_capture_if #(.H_SIZE(H), .V_SIZE(V)) a ();
  cam_pixel_capture_if #(.H_SIZE(H), .V_SIZE(V)) b ();

  cam_pixel_capture #(.H_SIZE(H), .V_SIZE(V), .HI_BYTE_FIRST(1'b1)) dut_a (
    .Cam_pclk (Cam_pclk),
    .Reset_n  (Reset_n),
    .bus      (a)
  );

  cam_pixel_capture #(.H_SIZE(H), .V_SIZE(V), .HI_BYTE_FIRST(1'b0)) dut_b (
    .Cam_pclk (Cam_pclk),
    .Reset_n  (Reset_n),
    .bus      (b)
  );

  initial Cam_pclk = 1'b0;
  always #5 Cam_pclk = ~Cam_pclk;

  int errors = 0;
  int checks = 0;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   le_cnt = 0;
  int   fd_cnt = 0;
  int   dbl_cnt = 0;
  logic prev_vld = 1'b0;
  pix_t mon_p;

  int         le_exp = 0;
  int         fd_exp = 0;
  int         ex_x = 0;
  int         ex_y = 0;
  int         nb = 0;
  bit         bad = 0;
  logic [1:0] ex_mode = 2'd0;

  always @(negedge Cam_pclk) begin
    if (a.pix_valid) begin
      mon_p.r  = a.red;
      mon_p.g  = a.green;
      mon_p.b  = a.blue;
      mon_p.x  = a.pix_x;
      mon_p.y  = a.pix_y;
      mon_p.fs = a.frame_start;
      got_q.push_back(mon_p);
      if (prev_vld) dbl_cnt++;
    end
    prev_vld = a.pix_valid;
    if (a.line_err) le_cnt++;
    if (a.frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference decode written arithmetically from the 16-bit word.
  function automatic logic [23:0] exp_rgb(input logic [1:0] m, input logic [7:0] hb, input logic [7:0] lb);
    int w, r, g, bl;
    w = {16'd0, hb, lb};
    case (m)
      2'd1: begin
        r = (w >> 10) & 31; g = (w >> 5) & 31; bl = w & 31;
        r = r * 8 + r / 4; g = g * 8 + g / 4; bl = bl * 8 + bl / 4;
      end
      2'd2: begin
        r = (w >> 8) & 15; g = (w >> 4) & 15; bl = w & 15;
        r = r * 17; g = g * 17; bl = bl * 17;
      end
      default: begin
        r = (w >> 11) & 31; g = (w >> 5) & 63; bl = w & 31;
        r = r * 8 + r / 4; g = g * 4 + g / 16; bl = bl * 8 + bl / 4;
      end
    endcase
    return {r[7:0], g[7:0], bl[7:0]};
  endfunction

  task automatic tick();
    @(posedge Cam_pclk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] d);
    a.Cam_href = 1'b1;
    a.Cam_data = d;
    tick();
    nb++;
  endtask

  task automatic push_pix(input logic [23:0] rgb);
    pix_t e;
    if (ex_x < H) begin
      e.r  = rgb[23:16];
      e.g  = rgb[15:8];
      e.b  = rgb[7:0];
      e.x  = ex_x[1:0];
      e.y  = ex_y[0];
      e.fs = (ex_x == 0) && (ex_y == 0);
      exp_q.push_back(e);
      ex_x++;
    end else begin
      bad = 1;
    end
  endtask

  task automatic pix_k(input logic [7:0] hb, input logic [7:0] lb, input logic [23:0] rgb);
    push_pix(rgb);
    put_byte(hb);
    put_byte(lb);
  endtask

  task automatic pix(input logic [7:0] hb, input logic [7:0] lb);
    pix_k(hb, lb, exp_rgb(ex_mode, hb, lb));
  endtask

  task automatic drain();
    pix_t g, e;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      chk("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("pixel_x%0d_y%0d", e.x, e.y), 32'(g), 32'(e));
      end
    end
    chk("pixels_missing", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic end_line();
    a.Cam_href = 1'b0;
    tick();
    tick();
    if ((ex_x != H) || nb[0] || bad) le_exp++;
    ex_y++;
    if (ex_y == V) fd_exp++;
    ex_x = 0;
    nb   = 0;
    bad  = 0;
    drain();
    chk("line_err_count", 32'(le_cnt), 32'(le_exp));
    chk("frame_done_count", 32'(fd_cnt), 32'(fd_exp));
    chk("strobe_width", 32'(dbl_cnt), 32'd0);
  endtask

  task automatic rnd_pix();
    pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic full_line();
    for (int k = 0; k < H; k++) rnd_pix();
    end_line();
  endtask

  task automatic frame_sync(input logic [1:0] m);
    a.Mode      = m;
    a.Cam_href  = 1'b0;
    a.Cam_vsync = 1'b1;
    tick();
    tick();
    a.Cam_vsync = 1'b0;
    tick();
    ex_mode = m;
    ex_y    = 0;
  endtask

  initial begin
    Reset_n     = 1'b0;
    a.Cam_vsync = 1'b0; a.Cam_href = 1'b0; a.Cam_data = 8'h00; a.Mode = 2'd0;
    b.Cam_vsync = 1'b0; b.Cam_href = 1'b0; b.Cam_data = 8'h00; b.Mode = 2'd0;
    #2;
    chk("reset_outputs", {1'b0, a.red, a.green, a.blue, a.pix_valid, a.pix_x, a.pix_y,
                          a.frame_start, a.frame_done, a.line_err}, 32'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    // Bytes before any vsync fall are ignored.
    put_byte(8'hF8); put_byte(8'h00);
    a.Cam_href = 1'b0; tick(); tick(); nb = 0;
    drain();

    // RGB565 full frame, first pixel F8 00 -> pure red with frame_start.
    frame_sync(2'd0);
    pix_k(8'hF8, 8'h00, 24'hFF0000);
    for (int k = 1; k < H; k++) rnd_pix();
    end_line();
    full_line();

    // RGB444; Mode change mid-frame must not take effect.
    frame_sync(2'd2);
    pix_k(8'h0A, 8'h5F, 24'hAA55FF);
    for (int k = 1; k < H; k++) rnd_pix();
    a.Mode = 2'd0;
    end_line();
    pix_k(8'h0A, 8'h5F, 24'hAA55FF);
    for (int k = 1; k < H; k++) rnd_pix();
    end_line();

    // RGB555 and the reserved mode (decoded as RGB565).
    frame_sync(2'd1);
    pix_k(8'h7C, 8'h00, 24'hFF0000);
    for (int k = 1; k < H; k++) rnd_pix();
    end_line();
    full_line();
    frame_sync(2'd3);
    pix_k(8'h07, 8'hE0, 24'h00FF00);
    for (int k = 1; k < H; k++) rnd_pix();
    end_line();
    full_line();

    // 7-byte line then 12-byte line.
    frame_sync(2'd0);
    for (int k = 0; k < 3; k++) rnd_pix();
    put_byte(8'h5A);
    end_line();
    for (int k = 0; k < 6; k++) rnd_pix();
    end_line();

    // vsync after first line only: error, no frame_done, restart at row 0.
    frame_sync(2'd0);
    full_line();
    a.Cam_vsync = 1'b1;
    tick();
    tick();
    le_exp++;
    chk("early_vsync_line_err", 32'(le_cnt), 32'(le_exp));
    chk("early_vsync_no_done", 32'(fd_cnt), 32'(fd_exp));
    frame_sync(2'd0);
    full_line();
    full_line();

    // Swapped byte order: 1F 00 -> lo=1F, hi=00 -> pure blue.
    b.Cam_vsync = 1'b1;
    tick();
    tick();
    b.Cam_vsync = 1'b0;
    tick();
    b.Cam_href = 1'b1; b.Cam_data = 8'h1F;
    tick();
    b.Cam_data = 8'h00;
    tick();
    @(negedge Cam_pclk);
    chk("swap_pix_valid", 32'(b.pix_valid), 32'd1);
    chk("swap_rgb", {8'h00, b.red, b.green, b.blue}, 32'h000000FF);
    b.Cam_href = 1'b0;
    tick();

    // Reset mid-pixel: outputs clear at once, capture waits for a new vsync fall.
    frame_sync(2'd0);
    pix_k(8'hF8, 8'h00, 24'hFF0000);
    put_byte(8'h12);
    drain();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {1'b0, a.red, a.green, a.blue, a.pix_valid, a.pix_x, a.pix_y,
                              a.frame_start, a.frame_done, a.line_err}, 32'd0);
    a.Cam_href = 1'b0;
    @(posedge Cam_pclk);
    #1;
    Reset_n = 1'b1;
    ex_x = 0; nb = 0; bad = 0;
    put_byte(8'h34); put_byte(8'h56); put_byte(8'h78); put_byte(8'h9A);
    a.Cam_href = 1'b0;
    tick();
    tick();
    nb = 0;
    drain();
    chk("post_reset_no_line_err", 32'(le_cnt), 32'(le_exp));
    frame_sync(2'd0);
    full_line();
    full_line();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
